// File: rtl/sha256_bus_if.sv
// Host-side interface for the SHA-256 core: packs host words into 512-bit blocks,
// hands them to the core over valid/ready and serialises the digest back MS word first.
module sha256_bus_if #(
  parameter int BUS_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             load,
  input  logic [BUS_W-1:0] idata,
  input  logic             fetch,
  output logic             ack,
  output logic [BUS_W-1:0] odata,
  output logic             busy,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [511:0]     blk_data,
  output logic             blk_first,
  input  logic             hash_done,
  input  logic [255:0]     hash,
  output logic             dig_ready
);
  localparam int BLK_WORDS = 512 / BUS_W;
  localparam int DIG_WORDS = 256 / BUS_W;
  localparam int WC_W      = $clog2(BLK_WORDS);
  localparam int RP_W      = $clog2(DIG_WORDS);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FILL    = 2'd1;
  localparam logic [1:0] HANDOFF = 2'd2;
  localparam logic [1:0] HASHING = 2'd3;

  if (BUS_W != 8 && BUS_W != 16 && BUS_W != 32) begin : g_bad_bus_w
    $error("sha256_bus_if: BUS_W must be 8, 16 or 32");
  end

  logic [1:0]      state;
  logic [WC_W-1:0] wcnt;
  logic [RP_W-1:0] rptr;
  logic [255:0]    digest;
  logic [255:0]    dig_shift;
  logic            take_init;
  logic            take_load;
  logic            take_fetch;

  assign busy       = (state == HANDOFF) || (state == HASHING);
  assign take_init  = init && !busy;
  assign take_load  = load && !init && !busy;
  // load has priority over fetch; fetch only reads a completed digest while idle
  assign take_fetch = fetch && !load && !init && (state == IDLE) && dig_ready;
  assign dig_shift  = digest << (32'(rptr) * BUS_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ack       <= 1'b0;
      odata     <= '0;
      blk_valid <= 1'b0;
      blk_data  <= '0;
      blk_first <= 1'b1;
      dig_ready <= 1'b0;
      wcnt      <= '0;
      rptr      <= '0;
      digest    <= '0;
    end else begin
      ack <= take_load || take_fetch;
      if (take_init) begin
        state     <= IDLE;
        wcnt      <= '0;
        blk_first <= 1'b1;
        dig_ready <= 1'b0;
        rptr      <= '0;
      end else begin
        case (state)
          IDLE, FILL: begin
            if (take_load) begin
              blk_data <= {blk_data[511-BUS_W:0], idata};
              // a new block invalidates the digest of the previous one
              if (wcnt == '0) begin
                dig_ready <= 1'b0;
                rptr      <= '0;
              end
              if (wcnt == WC_W'(BLK_WORDS - 1)) begin
                wcnt      <= '0;
                state     <= HANDOFF;
                blk_valid <= 1'b1;
              end else begin
                wcnt  <= wcnt + WC_W'(1);
                state <= FILL;
              end
            end else if (take_fetch) begin
              odata <= dig_shift[255 -: BUS_W];
              rptr  <= (rptr == RP_W'(DIG_WORDS - 1)) ? '0 : rptr + RP_W'(1);
            end
          end
          HANDOFF: begin
            if (blk_valid && blk_ready) begin
              blk_valid <= 1'b0;
              blk_first <= 1'b0;
              state     <= HASHING;
            end
          end
          HASHING: begin
            if (hash_done) begin
              digest    <= hash;
              dig_ready <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sha256_bus_if.sv
// Directed bench for sha256_bus_if at BUS_W = 8, 16 and 32 with a digest-word scoreboard.
module tb_sha256_bus_if;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         init_v [3];
  logic         load_v [3];
  logic         fetch_v[3];
  logic         rdy_v  [3];
  logic         hd_v   [3];
  logic [31:0]  idata;
  logic [255:0] hash_in;
  logic         ack_v  [3];
  logic         busy_v [3];
  logic         bv_v   [3];
  logic         bf_v   [3];
  logic         dr_v   [3];
  logic [511:0] bd_v   [3];
  logic [7:0]   od8;
  logic [15:0]  od16;
  logic [31:0]  od32;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [511:0] ABC = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [255:0] DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] HA  = 256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_13572468_9bdf0ace_2468ace0_fdb97531;
  localparam logic [255:0] HB  = 256'hdeadbeef_cafef00d_0badc0de_feedface_11112222_33334444_55556666_77778888;

  sha256_bus_if #(.BUS_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .init(init_v[0]), .load(load_v[0]), .idata(idata[7:0]),
    .fetch(fetch_v[0]), .ack(ack_v[0]), .odata(od8), .busy(busy_v[0]), .blk_valid(bv_v[0]),
    .blk_ready(rdy_v[0]), .blk_data(bd_v[0]), .blk_first(bf_v[0]), .hash_done(hd_v[0]),
    .hash(hash_in), .dig_ready(dr_v[0]));
  sha256_bus_if #(.BUS_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .init(init_v[1]), .load(load_v[1]), .idata(idata[15:0]),
    .fetch(fetch_v[1]), .ack(ack_v[1]), .odata(od16), .busy(busy_v[1]), .blk_valid(bv_v[1]),
    .blk_ready(rdy_v[1]), .blk_data(bd_v[1]), .blk_first(bf_v[1]), .hash_done(hd_v[1]),
    .hash(hash_in), .dig_ready(dr_v[1]));
  sha256_bus_if #(.BUS_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .init(init_v[2]), .load(load_v[2]), .idata(idata),
    .fetch(fetch_v[2]), .ack(ack_v[2]), .odata(od32), .busy(busy_v[2]), .blk_valid(bv_v[2]),
    .blk_ready(rdy_v[2]), .blk_data(bd_v[2]), .blk_first(bf_v[2]), .hash_done(hd_v[2]),
    .hash(hash_in), .dig_ready(dr_v[2]));

  function automatic logic [31:0] od(int w);
    case (w)
      0:       return {24'd0, od8};
      1:       return {16'd0, od16};
      default: return od32;
    endcase
  endfunction

  // word i of a block / digest as the host sees it, MS word first
  function automatic logic [31:0] w512(logic [511:0] b, int i, int bw);
    logic [511:0] t;
    t = b << (i * bw);
    return t[511:480] >> (32 - bw);
  endfunction

  function automatic logic [31:0] w256(logic [255:0] b, int i, int bw);
    logic [255:0] t;
    t = b << (i * bw);
    return t[255:224] >> (32 - bw);
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom())};
    return b;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int w, input logic [31:0] d, input logic exp_ack, input string tag);
    load_v[w] = 1'b1;
    idata     = d;
    tick();
    load_v[w] = 1'b0;
    chk(tag, 512'(ack_v[w]), 512'(exp_ack));
  endtask

  task automatic do_fetch(input int w, input logic exp_ack, input logic [31:0] word, input string tag);
    if (exp_ack) exp_q.push_back(word);
    fetch_v[w] = 1'b1;
    tick();
    fetch_v[w] = 1'b0;
    chk({tag, "_ack"}, 512'(ack_v[w]), 512'(exp_ack));
    if (ack_v[w] && exp_q.size() > 0) chk(tag, 512'(od(w)), 512'(exp_q.pop_front()));
  endtask

  task automatic pulse_init(input int w);
    init_v[w] = 1'b1;
    tick();
    init_v[w] = 1'b0;
    chk("init_no_ack", 512'(ack_v[w]), 512'(1'b0));
  endtask

  task automatic pulse_ready(input int w);
    rdy_v[w] = 1'b1;
    tick();
    rdy_v[w] = 1'b0;
  endtask

  task automatic pulse_hash(input int w, input logic [255:0] h);
    hash_in = h;
    hd_v[w] = 1'b1;
    tick();
    hd_v[w] = 1'b0;
  endtask

  task automatic load_block(input int w, input logic [511:0] b, input string tag);
    int bw;
    bw = 8 << w;
    for (int i = 0; i < 512 / bw; i++) begin
      if (i == 512 / bw - 1) chk({tag, "_valid_early"}, 512'(bv_v[w]), 512'(1'b0));
      do_load(w, w512(b, i, bw), 1'b1, {tag, "_ack"});
    end
  endtask

  task automatic run_abc(input int w);
    int bw;
    bw = 8 << w;
    pulse_init(w);
    load_block(w, ABC, "abc_load");
    chk("abc_valid", 512'(bv_v[w]), 512'(1'b1));
    chk("abc_data", bd_v[w], ABC);
    chk("abc_first", 512'(bf_v[w]), 512'(1'b1));
    chk("abc_busy", 512'(busy_v[w]), 512'(1'b1));
    for (int i = 0; i < 5; i++) do_load(w, 32'hffffffff, 1'b0, "abc_busy_load");
    chk("abc_stall_data", bd_v[w], ABC);
    chk("abc_stall_valid", 512'(bv_v[w]), 512'(1'b1));
    pulse_ready(w);
    chk("abc_hs_valid", 512'(bv_v[w]), 512'(1'b0));
    chk("abc_hs_first", 512'(bf_v[w]), 512'(1'b0));
    chk("abc_hashing_busy", 512'(busy_v[w]), 512'(1'b1));
    do_fetch(w, 1'b0, 32'd0, "abc_fetch_hashing");
    pulse_hash(w, DIG);
    chk("abc_dig_ready", 512'(dr_v[w]), 512'(1'b1));
    chk("abc_idle_busy", 512'(busy_v[w]), 512'(1'b0));
    for (int k = 0; k <= 256 / bw; k++) do_fetch(w, 1'b1, w256(DIG, k % (256 / bw), bw), "abc_dig");
    chk("abc_dig_ready_hold", 512'(dr_v[w]), 512'(1'b1));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [511:0] blk_a, blk_b, blk_c;
    rst_n   = 1'b0;
    idata   = '0;
    hash_in = '0;
    for (int w = 0; w < 3; w++) begin
      init_v[w] = 1'b0; load_v[w] = 1'b0; fetch_v[w] = 1'b0; rdy_v[w] = 1'b0; hd_v[w] = 1'b0;
    end
    tick();
    tick();
    for (int w = 0; w < 3; w++) begin
      chk("rst_ack", 512'(ack_v[w]), 512'(1'b0));
      chk("rst_odata", 512'(od(w)), 512'(0));
      chk("rst_busy", 512'(busy_v[w]), 512'(1'b0));
      chk("rst_valid", 512'(bv_v[w]), 512'(1'b0));
      chk("rst_data", bd_v[w], 512'(0));
      chk("rst_first", 512'(bf_v[w]), 512'(1'b1));
      chk("rst_dig_ready", 512'(dr_v[w]), 512'(1'b0));
    end
    rst_n = 1'b1;
    tick();

    run_abc(1);

    // two-block message with a stalled handoff
    blk_a = rand512();
    blk_b = rand512();
    pulse_init(1);
    load_block(1, blk_a, "blk_a");
    chk("blk_a_first", 512'(bf_v[1]), 512'(1'b1));
    for (int i = 0; i < 5; i++) begin
      do_load(1, 32'h0000a5a5, 1'b0, "stall_load");
      chk("stall_valid", 512'(bv_v[1]), 512'(1'b1));
      chk("stall_data", bd_v[1], blk_a);
      chk("stall_busy", 512'(busy_v[1]), 512'(1'b1));
    end
    pulse_ready(1);
    pulse_hash(1, HA);
    do_fetch(1, 1'b1, w256(HA, 0, 16), "ha_w0");
    load_v[1]  = 1'b1;
    fetch_v[1] = 1'b1;
    idata      = w512(blk_b, 0, 16);
    tick();
    load_v[1]  = 1'b0;
    fetch_v[1] = 1'b0;
    chk("ld_fetch_ack", 512'(ack_v[1]), 512'(1'b1));
    chk("ld_fetch_odata_hold", 512'(od16), 512'(w256(HA, 0, 16)));
    chk("ld_fetch_dig_clear", 512'(dr_v[1]), 512'(1'b0));
    for (int i = 1; i < 32; i++) do_load(1, w512(blk_b, i, 16), 1'b1, "blk_b_ack");
    chk("blk_b_valid", 512'(bv_v[1]), 512'(1'b1));
    chk("blk_b_first", 512'(bf_v[1]), 512'(1'b0));
    chk("blk_b_data", bd_v[1], blk_b);
    pulse_ready(1);
    pulse_hash(1, HB);
    do_fetch(1, 1'b1, w256(HB, 0, 16), "hb_w0");
    do_fetch(1, 1'b1, w256(HB, 1, 16), "hb_w1");
    pulse_hash(1, HA);
    chk("idle_hash_done_ready", 512'(dr_v[1]), 512'(1'b1));
    do_fetch(1, 1'b1, w256(HB, 2, 16), "idle_hash_done_ignored");

    // init discards partial blocks and wins over a same-cycle load
    blk_c = rand512();
    pulse_init(1);
    for (int i = 0; i < 10; i++) do_load(1, 32'($urandom()), 1'b1, "pre_init_load");
    pulse_init(1);
    do_fetch(1, 1'b0, 32'd0, "fetch_no_digest");
    for (int i = 0; i < 5; i++) do_load(1, 32'($urandom()), 1'b1, "pre_init_load2");
    init_v[1] = 1'b1;
    do_load(1, 32'h00001234, 1'b0, "init_load_no_ack");
    init_v[1] = 1'b0;
    load_block(1, blk_c, "blk_c");
    chk("blk_c_valid", 512'(bv_v[1]), 512'(1'b1));
    chk("blk_c_data", bd_v[1], blk_c);
    chk("blk_c_first", 512'(bf_v[1]), 512'(1'b1));
    pulse_ready(1);
    chk("blk_c_hashing", 512'(busy_v[1]), 512'(1'b1));

    // asynchronous reset in the middle of HASHING
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", 512'(ack_v[1]), 512'(1'b0));
    chk("arst_odata", 512'(od16), 512'(0));
    chk("arst_busy", 512'(busy_v[1]), 512'(1'b0));
    chk("arst_valid", 512'(bv_v[1]), 512'(1'b0));
    chk("arst_data", bd_v[1], 512'(0));
    chk("arst_first", 512'(bf_v[1]), 512'(1'b1));
    chk("arst_dig_ready", 512'(dr_v[1]), 512'(1'b0));
    #2;
    rst_n = 1'b1;
    tick();
    pulse_hash(1, HB);
    chk("post_rst_hash_ignored", 512'(dr_v[1]), 512'(1'b0));
    do_fetch(1, 1'b0, 32'd0, "post_rst_fetch");

    run_abc(0);
    run_abc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
